calc_core: RTL and testbench
============================

Name: calc_core

Overview:
- Arithmetic sequencer directly downstream of the keypad decode stage.
- Consumes decoded signed binary operands, operator codes and the overflow flag from that stage.
- Holds accumulator, pending operator and second operand; executes + - * / on '=' or on a chained operator.
- Drives the signed value and error flag for the display stage.

Parameters:
- WIDTH, 32, operand/result width (two's complement)
- MAX_MAG, 99999, largest displayable magnitude; any result beyond it is an error

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- in_valid  input  1  one-cycle strobe, asserted the cycle after the keypad stage updates its outputs
- in_is_op  input  1  1: in_op is meaningful; 0: in_data is meaningful
- in_data  input  WIDTH  signed operand from keypad stage
- in_op  input  5  operator code: 16 add, 15 sub, 14 mul, 13 div, 17 equals, 10 AC
- in_ovf  input  1  keypad-stage overflow flag, sampled with a number strobe
- disp_value  output  WIDTH  signed value to display
- disp_valid  output  1  one-cycle pulse when disp_value changes
- err  output  1  sticky error indicator
- busy  output  1  high while division iterates

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; acc, opb, pend_op, disp_value = 0; disp_valid, err, busy = 0. Reset mid-division aborts it with no result.
- Strobes are acted on only when in_valid=1. Codes other than the six listed are ignored.
- AC (10) in any state, including DIV and ERR: next cycle state IDLE, all registers 0, err=0, disp_value=0, disp_valid=1.
- Number strobe with in_ovf=1, in any non-ERR state: state ERR, err=1, disp_valid=1.
- States and transitions (valid, non-overflowed input):
  - IDLE: number -> acc=in_data, go HAVE_A, display it. Arithmetic op -> acc=0, pend_op=op, go HAVE_OP.
  - HAVE_A: number -> replace acc, display it. Arithmetic op -> pend_op=op, go HAVE_OP. '=' -> re-display acc.
  - HAVE_OP: number -> opb=in_data, go HAVE_B, display it. Arithmetic op -> replace pend_op. '=' -> ignored.
  - HAVE_B: number -> replace opb, display it. '=' or arithmetic op -> execute acc pend_op opb.
    - Trigger was '=': next state HAVE_A.
    - Trigger was an op: pend_op = trigger op, next state HAVE_OP.
  - DIV: busy=1 for exactly WIDTH cycles; non-AC strobes are dropped. Then result, and next state as in HAVE_B.
  - ERR: only AC leaves; everything else is ignored.
- Execution latency, with the trigger strobe at cycle t:
  - + - *: acc and disp_value updated, disp_valid=1 at t+1.
  - /: DIV runs cycles t+1 .. t+WIDTH; result and disp_valid at t+WIDTH+1.
- Arithmetic:
  - Add/sub in WIDTH+1 bits; multiply in 2*WIDTH bits, signed.
  - Divide: restoring, unsigned on magnitudes, one quotient bit per cycle. Sign = sign(acc) XOR sign(opb); truncate toward zero; remainder discarded.
  - Divisor 0: no iteration; ERR at t+1.
  - |result| > MAX_MAG: ERR, disp_value keeps its previous value, err=1.
- Simultaneous events: AC beats everything. At most one strobe per cycle is assumed; a strobe during the result cycle is processed in the new state.

Decomposition:
- Package calc_pkg: operator code constants (OP_ADD=16, OP_SUB=15, OP_MUL=14, OP_DIV=13, OP_EQ=17, OP_AC=10), state enum, MAX_MAG default.
- One sub-module: calc_div, the iterative signed divider.
  - Handshake: start, dividend, divisor in; done pulse, quotient out.
  - Fixed WIDTH-cycle latency; abort input for AC/reset.

Test Plan:
- Reset, then number 12, op 16, number 30, '=' -> disp_value=42 one cycle after '='; err=0.
- 7, op 15, 20, op 14 (chained), 3, '=' -> -13 after first op 14, then -39; pend_op=14 between them.
- -100, op 13, 7, '=' -> busy high exactly 32 cycles, then disp_value=-14, disp_valid one pulse; strobe 5 during busy is ignored.
- 5, op 13, 0, '=' -> err=1 at t+1; a following number 3 is ignored; AC -> err=0, disp_value=0.
- 99999, op 16, 1, '=' -> err=1, disp_value remains 1; 400, op 14, 250, '=' -> disp_value=100000 rejected (err=1).
- AC asserted on the 10th DIV cycle -> busy=0 and IDLE next cycle; no stale quotient appears; rst low mid-DIV gives the same result.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: operator codes, sequencer states and display limit shared by the calculator core
package calc_pkg;
    localparam logic [4:0] OP_ADD = 5'd16;
    localparam logic [4:0] OP_SUB = 5'd15;
    localparam logic [4:0] OP_MUL = 5'd14;
    localparam logic [4:0] OP_DIV = 5'd13;
    localparam logic [4:0] OP_EQ  = 5'd17;
    localparam logic [4:0] OP_AC  = 5'd10;
    localparam int MAX_MAG_DEF = 99999;
    typedef enum logic [2:0] {ST_IDLE, ST_HAVE_A, ST_HAVE_OP, ST_HAVE_B, ST_DIV, ST_ERR} state_t;
    function automatic logic is_arith(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    endfunction
endpackage

// File: rtl/calc_div.sv
// calc_div: restoring signed divider, one quotient bit per cycle, fixed WIDTH-cycle latency
// Ports: clk, rst (sync active-low), start/abort controls, dividend/divisor operands,
//        done pulse in the last iteration cycle with quotient valid alongside it.
module calc_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH);
    logic active, neg;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rem, q, d, rem_n, q_n;
    logic [WIDTH:0] rem_sh, diff;
    // Shift next dividend bit into the partial remainder; a clear borrow means the divisor fits.
    assign rem_sh = {rem, q[WIDTH-1]};
    assign diff = rem_sh - {1'b0, d};
    assign rem_n = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_n = {q[WIDTH-2:0], ~diff[WIDTH]};
    // The final bit is exposed combinationally so the result lands exactly WIDTH cycles after start.
    assign done = active && cnt == CW'(WIDTH - 1);
    assign quotient = neg ? -q_n : q_n;
    always_ff @(posedge clk)
        if (!rst || abort) begin
            active <= 1'b0;
            neg <= 1'b0;
            cnt <= '0;
            rem <= '0;
            q <= '0;
            d <= '0;
        end else if (start) begin
            active <= 1'b1;
            neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            cnt <= '0;
            rem <= '0;
            q <= dividend[WIDTH-1] ? -dividend : dividend;
            d <= divisor[WIDTH-1] ? -divisor : divisor;
        end else if (active) begin
            active <= !done;
            cnt <= cnt + 1'b1;
            rem <= rem_n;
            q <= q_n;
        end
endmodule

// File: rtl/calc_core.sv
// calc_core: calculator arithmetic sequencer between keypad decode and display
// Ports: clk, rst (sync active-low); in_valid/in_is_op/in_data/in_op/in_ovf from keypad stage;
//        disp_value/disp_valid to display, err sticky error, busy while dividing.
module calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MAX_MAG = MAX_MAG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_is_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_op,
    input  logic             in_ovf,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_valid,
    output logic             err,
    output logic             busy
);
    localparam logic signed [2*WIDTH-1:0] LIM = (2*WIDTH)'(MAX_MAG);
    state_t state, state_n;
    logic [WIDTH-1:0] acc, acc_n, opb, opb_n, disp_n, div_q;
    logic [4:0] pend_op, pend_n, trig_op, trig_n, exec_op;
    logic dv_n, err_n, div_start, div_done, apply, num, opv, is_ac;
    logic signed [2*WIDTH-1:0] a_w, b_w, q_w, res_w, val_w;
    assign num = in_valid && !in_is_op;
    assign opv = in_valid && in_is_op;
    assign is_ac = opv && in_op == OP_AC;
    assign busy = state == ST_DIV;
    assign a_w = {{WIDTH{acc[WIDTH-1]}}, acc};
    assign b_w = {{WIDTH{opb[WIDTH-1]}}, opb};
    assign q_w = {{WIDTH{div_q[WIDTH-1]}}, div_q};
    // Double-width arithmetic cannot wrap, so the range check sees the true result.
    assign res_w = pend_op == OP_ADD ? a_w + b_w : pend_op == OP_SUB ? a_w - b_w : a_w * b_w;
    assign val_w = state == ST_DIV ? q_w : res_w;
    assign exec_op = state == ST_DIV ? trig_op : in_op;
    calc_div #(.WIDTH(WIDTH)) u_div (
        .clk(clk),
        .rst(rst),
        .start(div_start),
        .abort(is_ac),
        .dividend(acc),
        .divisor(opb),
        .done(div_done),
        .quotient(div_q)
    );
    always_ff @(posedge clk)
        if (!rst) begin
            state <= ST_IDLE;
            acc <= '0;
            opb <= '0;
            pend_op <= '0;
            trig_op <= '0;
            disp_value <= '0;
            disp_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            acc <= acc_n;
            opb <= opb_n;
            pend_op <= pend_n;
            trig_op <= trig_n;
            disp_value <= disp_n;
            disp_valid <= dv_n;
            err <= err_n;
        end
    always_comb begin
        state_n = state;
        acc_n = acc;
        opb_n = opb;
        pend_n = pend_op;
        trig_n = trig_op;
        disp_n = disp_value;
        dv_n = 1'b0;
        err_n = err;
        div_start = 1'b0;
        apply = 1'b0;
        case (state)
            ST_IDLE:
                if (num) begin
                    acc_n = in_data;
                    disp_n = in_data;
                    dv_n = 1'b1;
                    state_n = ST_HAVE_A;
                end else if (opv && is_arith(in_op)) begin
                    acc_n = '0;
                    pend_n = in_op;
                    state_n = ST_HAVE_OP;
                end
            ST_HAVE_A:
                if (num) begin
                    acc_n = in_data;
                    disp_n = in_data;
                    dv_n = 1'b1;
                end else if (opv && is_arith(in_op)) begin
                    pend_n = in_op;
                    state_n = ST_HAVE_OP;
                end else if (opv && in_op == OP_EQ) begin
                    disp_n = acc;
                    dv_n = 1'b1;
                end
            ST_HAVE_OP:
                if (num) begin
                    opb_n = in_data;
                    disp_n = in_data;
                    dv_n = 1'b1;
                    state_n = ST_HAVE_B;
                end else if (opv && is_arith(in_op)) begin
                    pend_n = in_op;
                end
            ST_HAVE_B:
                if (num) begin
                    opb_n = in_data;
                    disp_n = in_data;
                    dv_n = 1'b1;
                end else if (opv && (is_arith(in_op) || in_op == OP_EQ)) begin
                    trig_n = in_op;
                    if (pend_op != OP_DIV) begin
                        apply = 1'b1;
                    end else if (opb == '0) begin
                        state_n = ST_ERR;
                        err_n = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        state_n = ST_DIV;
                    end
                end
            ST_DIV: apply = div_done;
            default: ;
        endcase
        if (apply) begin
            if (val_w > LIM || val_w < -LIM) begin
                state_n = ST_ERR;
                err_n = 1'b1;
            end else begin
                acc_n = val_w[WIDTH-1:0];
                disp_n = val_w[WIDTH-1:0];
                dv_n = 1'b1;
                state_n = exec_op == OP_EQ ? ST_HAVE_A : ST_HAVE_OP;
                pend_n = exec_op == OP_EQ ? pend_n : exec_op;
            end
        end
        // A divide in progress drops all number strobes, flagged or not.
        if (num && in_ovf && state != ST_ERR && state != ST_DIV) begin
            state_n = ST_ERR;
            err_n = 1'b1;
            dv_n = 1'b1;
        end
        if (is_ac) begin
            state_n = ST_IDLE;
            acc_n = '0;
            opb_n = '0;
            pend_n = '0;
            trig_n = '0;
            disp_n = '0;
            dv_n = 1'b1;
            err_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed self-checking bench for calc_core
module tb_calc_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_is_op = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0] in_op = '0;
    logic in_ovf = 1'b0;
    logic [31:0] disp_value;
    logic disp_valid, err, busy;
    int checks = 0;
    int errors = 0;

    calc_core dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_is_op(in_is_op),
        .in_data(in_data),
        .in_op(in_op),
        .in_ovf(in_ovf),
        .disp_value(disp_value),
        .disp_valid(disp_valid),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds the strobe for one rising edge and returns at the next negedge.
    task automatic strobe(input bit is_op, input int v, input bit ovf);
        in_valid = 1'b1;
        in_is_op = is_op;
        in_data = v;
        in_op = 5'(v);
        in_ovf = ovf;
        @(negedge clk);
        in_valid = 1'b0;
        in_ovf = 1'b0;
    endtask

    task automatic num(input int v);
        strobe(1'b0, v, 1'b0);
    endtask

    task automatic op(input int c);
        strobe(1'b1, c, 1'b0);
    endtask

    task automatic count_dv(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (disp_valid) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb, ndv, at;
        repeat (3) @(negedge clk);
        check("rst_disp", int'(disp_value), 0);
        check("rst_dv", int'(disp_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);

        num(12);
        check("num12_dv", int'(disp_valid), 1);
        check("num12_disp", int'($signed(disp_value)), 12);
        op(16); num(30); op(17);
        check("add_disp", int'($signed(disp_value)), 42);
        check("add_dv", int'(disp_valid), 1);
        check("add_err", int'(err), 0);

        num(7); op(15); num(20); op(14);
        check("chain_sub", int'($signed(disp_value)), -13);
        check("chain_sub_dv", int'(disp_valid), 1);
        num(3); op(17);
        check("chain_mul", int'($signed(disp_value)), -39);

        num(-100); op(13); num(7); op(17);
        nb = 0; ndv = 0; at = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (disp_valid) begin ndv++; at = i; end
            if (i == 3) begin in_valid = 1'b1; in_is_op = 1'b0; in_data = 5; end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        check("div_busy_cycles", nb, 32);
        check("div_dv_pulses", ndv, 1);
        check("div_dv_cycle", at, 32);
        check("div_result", int'($signed(disp_value)), -14);
        op(17);
        check("div_drop5", int'($signed(disp_value)), -14);

        op(10);
        check("ac_dv", int'(disp_valid), 1);
        num(5); op(13); num(0); op(17);
        check("div0_err", int'(err), 1);
        check("div0_busy", int'(busy), 0);
        num(3);
        check("err_ign_dv", int'(disp_valid), 0);
        check("err_ign_disp", int'($signed(disp_value)), 0);
        op(10);
        check("ac_err", int'(err), 0);
        check("ac_disp", int'($signed(disp_value)), 0);
        check("ac_dv2", int'(disp_valid), 1);

        num(99999); op(16); num(1); op(17);
        check("ovf_add_err", int'(err), 1);
        check("ovf_add_disp", int'($signed(disp_value)), 1);
        op(10);
        num(400); op(14); num(250); op(17);
        check("ovf_mul_err", int'(err), 1);
        check("ovf_mul_disp", int'($signed(disp_value)), 250);
        op(10);
        num(-99998); op(15); num(1); op(17);
        check("edge_neg_disp", int'($signed(disp_value)), -99999);
        check("edge_neg_err", int'(err), 0);
        strobe(1'b0, 5, 1'b1);
        check("kovf_err", int'(err), 1);
        check("kovf_dv", int'(disp_valid), 1);
        op(10);

        num(7); op(13); num(-2); op(16);
        repeat (32) @(negedge clk);
        check("divchain_dv", int'(disp_valid), 1);
        check("divchain_q", int'($signed(disp_value)), -3);
        num(10); op(17);
        check("divchain_add", int'($signed(disp_value)), 7);

        num(1000); op(13); num(3); op(17);
        repeat (9) @(negedge clk);
        op(10);
        check("acdiv_busy", int'(busy), 0);
        check("acdiv_disp", int'($signed(disp_value)), 0);
        check("acdiv_dv", int'(disp_valid), 1);
        @(negedge clk);
        count_dv(40, ndv);
        check("acdiv_stale", ndv, 0);
        num(4);
        check("acdiv_idle", int'($signed(disp_value)), 4);

        op(10);
        num(1000); op(13); num(3); op(17);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstdiv_busy", int'(busy), 0);
        check("rstdiv_disp", int'($signed(disp_value)), 0);
        check("rstdiv_dv", int'(disp_valid), 0);
        count_dv(40, ndv);
        check("rstdiv_stale", ndv, 0);
        num(6);
        check("rstdiv_idle", int'($signed(disp_value)), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
